// File: rtl/fu_issue_ctrl.sv
// Functional-unit issue control: maps compacted issue slots onto free lanes,
// times each op and arbitrates results onto the CDB. Macro FU_CDB_BYPASS_EN.
`ifndef WAYS
`define WAYS 3
`endif
`ifndef PRF
`define PRF 64
`endif
`ifndef XLEN
`define XLEN 32
`endif

module fu_issue_ctrl #(
   parameter int WAYS      = `WAYS,
   parameter int CDB_PORTS = `WAYS,
   parameter int MULT_LAT  = 4
) (
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic [WAYS-1:0]                        issue_valid,
   input  logic [WAYS-1:0]                        issue_mult,
   input  logic [WAYS-1:0][$clog2(`PRF)-1:0]      issue_tag,
   input  logic [WAYS-1:0][`XLEN-1:0]             lane_result,
   output logic [WAYS-1:0]                        ALU_occupied,
   output logic [WAYS-1:0]                        lane_start,
   output logic [WAYS-1:0][$clog2(WAYS)-1:0]      lane_slot,
   output logic [CDB_PORTS-1:0]                   CDB_valid,
   output logic [CDB_PORTS-1:0][$clog2(`PRF)-1:0] CDB_PRF_idx,
   output logic [CDB_PORTS-1:0][`XLEN-1:0]        CDB_Data
);
   localparam int TW = $clog2(`PRF);
   localparam int SW = $clog2(WAYS);
   localparam int CW = $clog2(MULT_LAT + 1);
   localparam int FW = $clog2(WAYS + 1);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      WAIT_CDB
   } lane_st_t;

   lane_st_t                   st_q [WAYS];
   lane_st_t                   st_d [WAYS];
   logic [WAYS-1:0][CW-1:0]    cnt_q, cnt_d;
   logic [WAYS-1:0][TW-1:0]    tag_q, tag_d;
   logic [WAYS-1:0][`XLEN-1:0] data_q, data_d;
   logic [SW-1:0]              ptr_q, ptr_d;
   logic [WAYS-1:0]            grant;
   logic [FW-1:0]              free_cnt;

   always_comb begin
      for (int i = 0; i < WAYS; i++)
         ALU_occupied[i] = (st_q[i] != IDLE);
   end

   // Slot k lands on the k-th free lane in ascending lane order.
   always_comb begin
      int nfree;
      nfree = 0;
      lane_start = '0;
      lane_slot = '0;
      for (int i = 0; i < WAYS; i++) begin
         lane_slot[i] = SW'(nfree);
         if (!ALU_occupied[i]) begin
            lane_start[i] = issue_valid[nfree] && !reset;
            nfree++;
         end
      end
      free_cnt = FW'(nfree);
   end

`ifdef FU_CDB_BYPASS_EN
   logic [WAYS-1:0]         done;
   logic [WAYS-1:0]         byp;
   logic [WAYS-1:0][TW-1:0] cur_tag;

   always_comb begin
      for (int i = 0; i < WAYS; i++) begin
         if (st_q[i] == IDLE) begin
            done[i] = lane_start[i] && !issue_mult[lane_slot[i]];
            cur_tag[i] = issue_tag[lane_slot[i]];
         end else begin
            done[i] = (st_q[i] == EXEC) && (cnt_q[i] == CW'(1));
            cur_tag[i] = tag_q[i];
         end
      end
   end
`endif

   always_comb begin
      int idx;
      int used;
      int last;
      grant = '0;
      CDB_valid = '0;
      CDB_PRF_idx = '0;
      CDB_Data = '0;
      ptr_d = ptr_q;
      used = 0;
      last = -1;
      idx = 0;
`ifdef FU_CDB_BYPASS_EN
      byp = '0;
`endif
      if (!reset) begin
         for (int j = 0; j < WAYS; j++) begin
            idx = int'(ptr_q) + j;
            if (idx >= WAYS) idx -= WAYS;
            if (st_q[idx] == WAIT_CDB && used < CDB_PORTS) begin
               grant[idx] = 1'b1;
               CDB_valid[used] = 1'b1;
               CDB_PRF_idx[used] = tag_q[idx];
               CDB_Data[used] = data_q[idx];
               used++;
               last = idx;
            end
         end
`ifdef FU_CDB_BYPASS_EN
         // Completing lanes take whatever ports the held results left over.
         for (int j = 0; j < WAYS; j++) begin
            idx = int'(ptr_q) + j;
            if (idx >= WAYS) idx -= WAYS;
            if (done[idx] && used < CDB_PORTS) begin
               byp[idx] = 1'b1;
               CDB_valid[used] = 1'b1;
               CDB_PRF_idx[used] = cur_tag[idx];
               CDB_Data[used] = lane_result[idx];
               used++;
               last = idx;
            end
         end
`endif
         if (last >= 0)
            ptr_d = (last == WAYS - 1) ? '0 : SW'(last + 1);
      end
   end

   always_comb begin
      st_d = st_q;
      cnt_d = cnt_q;
      tag_d = tag_q;
      data_d = data_q;
      for (int i = 0; i < WAYS; i++) begin
         unique case (st_q[i])
            IDLE: begin
               if (lane_start[i]) begin
                  tag_d[i] = issue_tag[lane_slot[i]];
                  if (issue_mult[lane_slot[i]]) begin
                     st_d[i] = EXEC;
                     cnt_d[i] = CW'(MULT_LAT - 1);
                  end else begin
                     st_d[i] = WAIT_CDB;
                     data_d[i] = lane_result[i];
                  end
               end
            end
            EXEC: begin
               if (cnt_q[i] == CW'(1)) begin
                  st_d[i] = WAIT_CDB;
                  data_d[i] = lane_result[i];
               end else begin
                  cnt_d[i] = cnt_q[i] - CW'(1);
               end
            end
            WAIT_CDB: begin
               if (grant[i]) st_d[i] = IDLE;
            end
            default: st_d[i] = IDLE;
         endcase
`ifdef FU_CDB_BYPASS_EN
         if (byp[i]) st_d[i] = IDLE;
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < WAYS; i++) st_q[i] <= IDLE;
         cnt_q <= '0;
         tag_q <= '0;
         data_q <= '0;
         ptr_q <= '0;
      end else begin
         for (int i = 0; i < WAYS; i++) st_q[i] <= st_d[i];
         cnt_q <= cnt_d;
         tag_q <= tag_d;
         data_q <= data_d;
         ptr_q <= ptr_d;
      end
   end

`ifndef SYNTHESIS
   always @(posedge clock) begin
      if (!reset) begin
         for (int k = 0; k < WAYS; k++)
            assert (!issue_valid[k] || int'(free_cnt) > k)
            else $error("issue slot %0d valid with only %0d free lanes", k, free_cnt);
      end
   end
`endif

endmodule

// File: doc/fu_issue_ctrl.md
FU_ISSUE_CTRL -- requirements
Module: fu_issue_ctrl

Interface
REQ-001 SHALL provide parameter WAYS, default `WAYS, number of execution lanes and issue slots.
REQ-002 SHALL provide parameter CDB_PORTS, default `WAYS, number of CDB broadcast ports (1..WAYS).
REQ-003 SHALL provide parameter MULT_LAT, default 4, multi-cycle op latency in cycles (>=2).
REQ-004 SHALL have one clock and a synchronous active-high reset, ports clock and reset.
REQ-005 Ports (name  direction  width  meaning):
- clock  in  1  sole clock.
- reset  in  1  synchronous, active-high.
- issue_valid  in  WAYS  issued packet valid per compacted RS output slot, LSB-packed.
- issue_mult  in  WAYS  slot k carries a multi-cycle (MULT_LAT) op.
- issue_tag  in  WAYS x $clog2(`PRF)  destination PRF index per slot.
- lane_result  in  WAYS x `XLEN  datapath result per lane, valid in the lane's completion cycle.
- ALU_occupied  out  WAYS  lane busy mask, fed to the RS output selector.
- lane_start  out  WAYS  lane accepts an op this cycle.
- lane_slot  out  WAYS x $clog2(WAYS)  compacted slot feeding each lane.
- CDB_valid  out  CDB_PORTS  broadcast valid, LSB-packed (1, 11, 111...).
- CDB_PRF_idx  out  CDB_PORTS x $clog2(`PRF)  broadcast tag.
- CDB_Data  out  CDB_PORTS x `XLEN  broadcast data.

Function
REQ-006 Each lane SHALL hold one state: IDLE, EXEC (down-counter, width $clog2(MULT_LAT+1)), or WAIT_CDB (holding tag and result).
REQ-007 ALU_occupied[i] SHALL equal (lane i state != IDLE), decoded from registers only, with no combinational path from any input.
REQ-008 Compacted slot k SHALL map to the k-th lane, ascending index, whose ALU_occupied is 0.
- lane_start and lane_slot are combinational on that mapping.
- issue_valid[k] with fewer than k+1 free lanes is a protocol violation, flagged by a simulation assertion.
REQ-009 On lane_start at cycle T, the lane SHALL enter EXEC with counter = (issue_mult ? MULT_LAT : 1).
- The counter decrements each cycle.
- The lane's completion cycle is T+L-1.
REQ-010 At the clock edge ending the completion cycle, the lane SHALL capture lane_result and tag and enter WAIT_CDB.
REQ-011 Each cycle, up to CDB_PORTS WAIT_CDB lanes SHALL be granted using a rotating-priority pointer.
- Grants are placed on CDB ports 0,1,... in priority order.
- Unused ports carry valid=0 and tag/data 0.
REQ-012 After granting, the pointer SHALL advance to (last granted lane + 1) mod WAYS, and SHALL hold if nothing was granted.
REQ-013 A granted lane SHALL be IDLE on the next cycle and SHALL NOT accept issue in its grant cycle.
- An ungranted lane stays in WAIT_CDB with its data unchanged.
REQ-014 Minimum issue-to-broadcast latency SHALL be L+1 cycles when FU_CDB_BYPASS_EN is undefined.
REQ-015 When all lanes are occupied, ALU_occupied SHALL be all ones and no lane_start SHALL assert, regardless of issue_valid.

Reset
REQ-016 While reset is high, all lanes SHALL go IDLE and the pointer to 0.
REQ-017 Reset SHALL clear ALU_occupied, CDB_valid, lane_start and hold registers to 0.
REQ-018 Reset mid-operation SHALL discard in-flight and waiting results without broadcasting them.
REQ-019 Issue inputs SHALL be ignored in any cycle where reset is high.

Configuration
REQ-020 When macro FU_CDB_BYPASS_EN is defined, a lane in its completion cycle SHALL broadcast lane_result directly.
- Applies only when a CDB port remains after WAIT_CDB grants.
- Completing lanes rank below WAIT_CDB lanes, in rotating order.
- A bypassed lane goes IDLE next cycle; minimum latency becomes L.
REQ-021 When FU_CDB_BYPASS_EN is undefined, every result SHALL pass through the WAIT_CDB hold register.

Verification (WAYS=3, CDB_PORTS=2, MULT_LAT=4)
REQ-022 Reset, then idle -> ALU_occupied=000 and CDB_valid=00 every cycle.
REQ-023 Cycle 1: issue_valid=001, non-mult, tag 5, lane_result[0]=0x11 in cycle 1 -> cycle 2: CDB_valid=01, tag 5, data 0x11, ALU_occupied=001; cycle 3: ALU_occupied=000.
REQ-024 ALU_occupied=010, issue_valid=011 -> lane_slot[0]=0, lane_slot[2]=1, lane_start=101.
REQ-025 Mult op issued at cycle 1 -> CDB broadcast at cycle 5 (bypass undefined), ALU_occupied[lane] high in cycles 2..5.
REQ-026 Three single-cycle ops issued together, pointer 0 -> cycle 2: lanes 0,1 broadcast; cycle 3: lane 2 broadcasts with ALU_occupied=100; pointer ends at 0.
REQ-027 Reset asserted with a mult op in EXEC -> no CDB_valid is ever produced for that tag, and ALU_occupied=000 the cycle after reset.
